// File: rtl/expander.sv
// Sample expander: holds each accepted sample and emits it cfg_rep+1 times.
// Optional macro EXPANDER_EVT_FIRST_EN: event flags appear on the first copy only.
module expander #(
    parameter int SDW = 32,
    parameter int SCW = 32,
    parameter int SEW = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [SCW-1:0] cfg_rep,
    input  logic [SDW-1:0] sti_tdata,
    input  logic [SEW-1:0] sti_tevent,
    input  logic           sti_tvalid,
    output logic           sti_tready,
    output logic [SDW-1:0] sto_tdata,
    output logic [SEW-1:0] sto_tevent,
    output logic           sto_tvalid,
    input  logic           sto_tready
);

    typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [SDW-1:0] data_q, data_d;
    logic [SEW-1:0] evt_q, evt_d;
    logic [SCW-1:0] cnt_q, cnt_d;
    logic           cnt_zero;
    logic           in_xfer;
    logic           out_xfer;

    // cnt counts remaining extra copies, so all-ones yields 2^SCW beats without wrapping.
    assign cnt_zero   = (cnt_q == '0);
    assign sti_tready = (state_q == EMPTY) | (sto_tready & cnt_zero);
    assign in_xfer    = sti_tvalid & sti_tready;
    assign out_xfer   = (state_q == HOLD) & sto_tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            evt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            evt_q   <= evt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        evt_d   = evt_q;
        cnt_d   = cnt_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d = HOLD;
                    data_d  = sti_tdata;
                    evt_d   = sti_tevent;
                    cnt_d   = cfg_rep;
                end
            end
            HOLD: begin
                // An input transfer in HOLD implies the last copy is leaving: reload with no bubble.
                if (in_xfer) begin
                    data_d = sti_tdata;
                    evt_d  = sti_tevent;
                    cnt_d  = cfg_rep;
                end else if (out_xfer) begin
                    if (!cnt_zero) begin
                        cnt_d = cnt_q - 1'b1;
`ifdef EXPANDER_EVT_FIRST_EN
                        evt_d = '0;
`endif
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        sto_tvalid = (state_q == HOLD);
        sto_tdata  = data_q;
        sto_tevent = evt_q;
    end

endmodule

// File: tb/tb_expander.sv
// Scoreboard bench for expander: expected copies queued at input accept, compared at output.
module tb_expander;

    localparam int SDW = 16;
    localparam int SCW = 4;
    localparam int SEW = 1;
`ifdef EXPANDER_EVT_FIRST_EN
    localparam bit EVT_FIRST = 1'b1;
`else
    localparam bit EVT_FIRST = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [SCW-1:0] cfg_rep = '0;
    logic [SDW-1:0] sti_tdata = '0;
    logic [SEW-1:0] sti_tevent = '0;
    logic           sti_tvalid = 1'b0;
    logic           sti_tready;
    logic [SDW-1:0] sto_tdata;
    logic [SEW-1:0] sto_tevent;
    logic           sto_tvalid;
    logic           sto_tready = 1'b1;

    expander #(.SDW(SDW), .SCW(SCW), .SEW(SEW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_rep    (cfg_rep),
        .sti_tdata  (sti_tdata),
        .sti_tevent (sti_tevent),
        .sti_tvalid (sti_tvalid),
        .sti_tready (sti_tready),
        .sto_tdata  (sto_tdata),
        .sto_tevent (sto_tevent),
        .sto_tvalid (sto_tvalid),
        .sto_tready (sto_tready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SDW-1:0] data;
        logic [SEW-1:0] evt;
        logic           last;
    } ent_t;

    ent_t           sbq[$];
    logic [SDW-1:0] samp_out[$];
    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    int             beats = 0;
    int             ev_beats = 0;
    int             first_acc = -1;
    int             first_out = -1;
    int             last_out = -1;
    int             samp_cnt = 0;
    bit             mon_en = 1'b0;
    bit             tog_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (tog_en) sto_tready = ~sto_tready;
    end

    // Monitor: compare the presented beat with the queue head, then record new accepts.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (sto_tvalid) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected: got data %0h with empty scoreboard", sto_tdata);
                end else begin
                    ent_t e;
                    logic exp_rdy;
                    e = sbq[0];
                    if (sto_tdata !== e.data || sto_tevent !== e.evt) begin
                        errors++;
                        $display("FAIL out_beat: got data %0h evt %0h, expected data %0h evt %0h",
                                 sto_tdata, sto_tevent, e.data, e.evt);
                    end
                    exp_rdy = e.last ? sto_tready : 1'b0;
                    checks++;
                    if (sti_tready !== exp_rdy) begin
                        errors++;
                        $display("FAIL ready_hold: got sti_tready %0b, expected %0b", sti_tready, exp_rdy);
                    end
                    if (sto_tready) begin
                        void'(sbq.pop_front());
                        beats++;
                        if (sto_tevent != '0) ev_beats++;
                        if (first_out < 0) first_out = cyc;
                        last_out = cyc;
                        if (samp_cnt == 0) samp_out.push_back(sto_tdata);
                        samp_cnt = (samp_cnt == 3) ? 0 : samp_cnt + 1;
                    end
                end
            end else begin
                checks++;
                if (sti_tready !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_empty: got sti_tready %0b, expected 1", sti_tready);
                end
            end
            if (sti_tvalid && sti_tready) begin
                if (first_acc < 0) first_acc = cyc;
                for (int k = 0; k <= int'(cfg_rep); k++) begin
                    ent_t n;
                    n.data = sti_tdata;
                    n.evt  = (k == 0 || !EVT_FIRST) ? sti_tevent : '0;
                    n.last = (k == int'(cfg_rep));
                    sbq.push_back(n);
                end
            end
        end
    end

    task automatic clear_stats();
        beats     = 0;
        ev_beats  = 0;
        first_acc = -1;
        first_out = -1;
        last_out  = -1;
        samp_cnt  = 0;
        samp_out.delete();
    endtask

    task automatic send(input logic [SDW-1:0] d, input logic [SEW-1:0] ev);
        int   t;
        logic acc;
        t = 0;
        acc = 1'b0;
        sti_tdata  = d;
        sti_tevent = ev;
        sti_tvalid = 1'b1;
        do begin
            @(negedge clk);
            acc = sti_tready;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 200);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: sample %0h not accepted within 200 cycles", d);
        end
    endtask

    task automatic idle();
        sti_tvalid = 1'b0;
        sti_tevent = '0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (!(sbq.size() == 0 && !sto_tvalid) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (t >= 300) begin
            errors++;
            $display("FAIL drain_timeout: %0d entries left, sto_tvalid %0b", sbq.size(), sto_tvalid);
        end
    endtask

    task automatic check_beats(input string name, input int exp);
        checks++;
        if (beats != exp) begin
            errors++;
            $display("FAIL %s: got %0d beats, expected %0d", name, beats, exp);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #3;
        checks++;
        if (sto_tvalid !== 1'b0 || sti_tready !== 1'b1 || sto_tdata !== '0 || sto_tevent !== '0) begin
            errors++;
            $display("FAIL reset_state: vld %0b rdy %0b data %0h evt %0h, expected 0 1 0 0",
                     sto_tvalid, sti_tready, sto_tdata, sto_tevent);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (sti_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %0b, expected 1", sti_tready);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        cfg_rep = 0;
        clear_stats();
        for (int i = 0; i < 8; i++) send(SDW'(i), '0);
        idle();
        drain();
        check_beats("b2b_beats", 8);
        checks++;
        if (first_out - first_acc != 1) begin
            errors++;
            $display("FAIL b2b_latency: got %0d cycles, expected 1", first_out - first_acc);
        end
        checks++;
        if (last_out - first_out != 7) begin
            errors++;
            $display("FAIL b2b_rate: got span %0d cycles, expected 7", last_out - first_out);
        end
    endtask

    task automatic test_rep1();
        cfg_rep = 1;
        clear_stats();
        for (int i = 0; i < 8; i++) send(SDW'(i), '0);
        idle();
        drain();
        check_beats("rep1_beats", 16);
    endtask

    task automatic test_stall();
        cfg_rep = 2;
        clear_stats();
        tog_en = 1'b1;
        for (int i = 0; i < 8; i++) send(SDW'(i), '0);
        idle();
        drain();
        tog_en = 1'b0;
        @(posedge clk);
        #2 sto_tready = 1'b1;
        check_beats("stall_beats", 24);
    endtask

    task automatic test_sampler();
        cfg_rep = 3;
        clear_stats();
        for (int i = 0; i < 8; i++) send(SDW'(i), '0);
        idle();
        drain();
        checks++;
        if (samp_out.size() != 8) begin
            errors++;
            $display("FAIL sampler_count: got %0d samples, expected 8", samp_out.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (samp_out[i] !== SDW'(i)) begin
                    errors++;
                    $display("FAIL sampler_data: index %0d got %0h, expected %0h", i, samp_out[i], i);
                end
            end
        end
    endtask

    task automatic test_event();
        cfg_rep = 2;
        clear_stats();
        send(16'd4, 1'b0);
        send(16'd5, 1'b1);
        send(16'd6, 1'b0);
        idle();
        drain();
        checks++;
        if (ev_beats != (EVT_FIRST ? 1 : 3)) begin
            errors++;
            $display("FAIL event_copies: got %0d event beats, expected %0d", ev_beats, EVT_FIRST ? 1 : 3);
        end
    endtask

    task automatic test_cfg_change();
        cfg_rep = 2;
        clear_stats();
        send(16'h10, '0);
        cfg_rep = 0;
        send(16'h11, '0);
        idle();
        drain();
        check_beats("cfg_change_beats", 4);
    endtask

    task automatic test_max_rep();
        cfg_rep = '1;
        clear_stats();
        send(16'h20, '0);
        send(16'h21, '0);
        idle();
        drain();
        check_beats("max_rep_beats", 32);
    endtask

    task automatic test_reset_mid();
        int t;
        cfg_rep = 3;
        clear_stats();
        send(16'h2, '0);
        send(16'h3, '0);
        idle();
        t = 0;
        while (beats < 5 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (beats != 5) begin
            errors++;
            $display("FAIL reset_mid_position: got %0d beats, expected 5", beats);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (sto_tvalid !== 1'b0 || sto_tdata !== '0) begin
            errors++;
            $display("FAIL reset_mid_clear: vld %0b data %0h, expected 0 0", sto_tvalid, sto_tdata);
        end
        sbq.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (sti_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready: got %0b, expected 1", sti_tready);
        end
        cfg_rep = 0;
        clear_stats();
        send(16'h9, '0);
        idle();
        drain();
        check_beats("reset_mid_after", 1);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_rep1();
        test_stall();
        test_sampler();
        test_event();
        test_cfg_change();
        test_max_rep();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
